// File: rtl/wb_ctrl.sv
// Register-file write-back controller: result FIFO, priority external writes,
// per-register pending-write scoreboard driving decode pause.
module wb_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  output logic        issue_ready,
  input  logic        res_valid,
  input  logic [4:0]  res_addr,
  input  logic [31:0] res_data,
  output logic        res_ready,
  input  logic        ext_we,
  input  logic [4:0]  ext_addr,
  input  logic [31:0] ext_data,
  output logic        RegWE,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data,
  input  logic [4:0]  read_addr1,
  input  logic [4:0]  read_addr2,
  output logic [1:0]  pause,
  output logic        err
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Result FIFO; pointers carry an extra wrap bit to tell full from empty.
  logic [4:0]  fifo_addr [FIFO_DEPTH];
  logic [31:0] fifo_data [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic [4:0]  head_addr;
  logic [31:0] head_data;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign res_ready = !full;
  assign push      = res_valid && !full;
  assign pop       = !ext_we && !empty;
  assign head_addr = fifo_addr[rd_ptr[AW-1:0]];
  assign head_data = fifo_data[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[AW-1:0]] <= res_addr;
      fifo_data[wr_ptr[AW-1:0]] <= res_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Registered write port; from_fifo marks writes that retire a reservation.
  logic from_fifo;

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWE      <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      from_fifo  <= 1'b0;
    end else if (ext_we) begin
      RegWE      <= (ext_addr != '0);
      write_addr <= ext_addr;
      write_data <= ext_data;
      from_fifo  <= 1'b0;
    end else if (!empty) begin
      RegWE      <= (head_addr != '0);
      write_addr <= head_addr;
      write_data <= head_data;
      from_fifo  <= 1'b1;
    end else begin
      RegWE      <= 1'b0;
      from_fifo  <= 1'b0;
    end
  end

  // Pending-write scoreboard.
  logic [CNT_W-1:0] cnt     [32];
  logic [CNT_W-1:0] cnt_nxt [32];
  logic             inc;
  logic             dec;
  logic             err_set;

  assign issue_ready = !((issue_addr != '0) && (cnt[issue_addr] == '1));
  assign inc         = issue_valid && issue_ready && (issue_addr != '0);
  assign dec         = RegWE && from_fifo;

  always_comb begin
    for (int unsigned r = 0; r < 32; r++) cnt_nxt[r] = cnt[r];
    err_set = 1'b0;
    if (inc) cnt_nxt[issue_addr] = cnt[issue_addr] + CNT_W'(1);
    if (dec) begin
      if (cnt[write_addr] == '0) err_set = 1'b1;
      // A same-register reserve and retire cancel out.
      if (inc && (issue_addr == write_addr))
        cnt_nxt[write_addr] = cnt[write_addr];
      else if (cnt[write_addr] != '0)
        cnt_nxt[write_addr] = cnt[write_addr] - CNT_W'(1);
    end
    cnt_nxt[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < 32; r++) cnt[r] <= '0;
      err <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < 32; r++) cnt[r] <= cnt_nxt[r];
      if (err_set) err <= 1'b1;
    end
  end

  assign pause[0] = (read_addr1 != '0) && (cnt[read_addr1] != '0);
  assign pause[1] = (read_addr2 != '0) && (cnt[read_addr2] != '0);

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl with hand-computed expectations.
module tb_wb_ctrl;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        issue_ready;
  logic        res_valid;
  logic [4:0]  res_addr;
  logic [31:0] res_data;
  logic        res_ready;
  logic        ext_we;
  logic [4:0]  ext_addr;
  logic [31:0] ext_data;
  logic        RegWE;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic [1:0]  pause;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  wb_ctrl #(.FIFO_DEPTH(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data), .res_ready(res_ready),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
    .RegWE(RegWE), .write_addr(write_addr), .write_data(write_data),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .pause(pause), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [4:0] a, input logic [31:0] d);
    res_valid = 1'b1;
    res_addr  = a;
    res_data  = d;
    tick();
    res_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_addr = '0;
    res_valid = 1'b0; res_addr = '0; res_data = '0;
    ext_we = 1'b0; ext_addr = '0; ext_data = '0;
    read_addr1 = '0; read_addr2 = '0;
    tick(); tick();
    rst = 1'b0;
    read_addr1 = 5'd5; read_addr2 = 5'd7; issue_addr = 5'd7;
    #1;
    chk("rst_regwe", 32'(RegWE), 32'd0);
    chk("rst_waddr", 32'(write_addr), 32'd0);
    chk("rst_wdata", write_data, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pause", 32'(pause), 32'd0);
    chk("rst_res_ready", 32'(res_ready), 32'd1);
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);

    // Single result through the FIFO to r5
    issue_valid = 1'b1; issue_addr = 5'd5; read_addr2 = 5'd0;
    tick();
    issue_valid = 1'b0;
    #1;
    chk("single_pause_set", 32'(pause), 32'b01);
    push_one(5'd5, 32'hDEADBEEF);
    chk("single_no_early_we", 32'(RegWE), 32'd0);
    tick();
    chk("single_regwe", 32'(RegWE), 32'd1);
    chk("single_waddr", 32'(write_addr), 32'd5);
    chk("single_wdata", write_data, 32'hDEADBEEF);
    chk("single_pause_hold", 32'(pause), 32'b01);
    tick();
    chk("single_pause_clear", 32'(pause), 32'b00);
    chk("single_regwe_low", 32'(RegWE), 32'd0);
    chk("single_waddr_hold", 32'(write_addr), 32'd5);
    chk("single_wdata_hold", write_data, 32'hDEADBEEF);
    chk("single_err", 32'(err), 32'd0);

    // Saturation of r7's counter
    issue_addr = 5'd7; issue_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("sat_ready_pre", 32'(issue_ready), 32'd1);
      tick();
    end
    issue_valid = 1'b0;
    #1;
    chk("sat_ready_r7", 32'(issue_ready), 32'd0);
    issue_addr = 5'd8;
    #1;
    chk("sat_ready_r8", 32'(issue_ready), 32'd1);
    issue_addr = 5'd7;
    push_one(5'd7, 32'h0000_0077);
    tick();
    chk("sat_commit_we", 32'(RegWE), 32'd1);
    chk("sat_still_full", 32'(issue_ready), 32'd0);
    tick();
    chk("sat_ready_back", 32'(issue_ready), 32'd1);

    // FIFO full while external writes hold the port
    issue_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue_addr = 5'(11 + i);
      tick();
    end
    issue_valid = 1'b0; issue_addr = '0;
    ext_we = 1'b1; ext_addr = 5'd10; ext_data = 32'hE0E0E0E0;
    for (int i = 0; i < 4; i++) begin
      res_valid = 1'b1; res_addr = 5'(11 + i); res_data = 32'hA1 + 32'(i);
      #1;
      chk("full_ready_pre", 32'(res_ready), 32'd1);
      tick();
      chk("ext_regwe", 32'(RegWE), 32'd1);
      chk("ext_waddr", 32'(write_addr), 32'd10);
      chk("ext_wdata", write_data, 32'hE0E0E0E0);
    end
    res_addr = 5'd15; res_data = 32'hA5;
    #1;
    chk("full_ready_low", 32'(res_ready), 32'd0);
    tick();
    res_valid = 1'b0; ext_we = 1'b0;
    read_addr1 = 5'd10;
    #1;
    chk("ext_no_cnt", 32'(pause), 32'b00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_regwe", 32'(RegWE), 32'd1);
      chk("drain_waddr", 32'(write_addr), 32'(11 + i));
      chk("drain_wdata", write_data, 32'hA1 + 32'(i));
    end
    chk("drain_res_ready", 32'(res_ready), 32'd1);
    tick();
    chk("drain_done", 32'(RegWE), 32'd0);
    chk("drain_waddr_hold", 32'(write_addr), 32'd14);
    read_addr1 = 5'd14; read_addr2 = 5'd13;
    #1;
    chk("drain_pause", 32'(pause), 32'b00);
    chk("drain_err", 32'(err), 32'd0);

    // Register zero
    read_addr1 = 5'd0; read_addr2 = 5'd0;
    issue_valid = 1'b1; issue_addr = 5'd0;
    #1;
    chk("r0_issue_ready", 32'(issue_ready), 32'd1);
    tick();
    issue_valid = 1'b0;
    push_one(5'd0, 32'h1234);
    chk("r0_pause", 32'(pause), 32'b00);
    tick();
    chk("r0_regwe", 32'(RegWE), 32'd0);
    tick();
    chk("r0_regwe2", 32'(RegWE), 32'd0);
    chk("r0_err", 32'(err), 32'd0);

    // Simultaneous reserve and retire of r4 leave its count unchanged
    read_addr2 = 5'd4;
    issue_valid = 1'b1; issue_addr = 5'd4;
    tick();
    issue_valid = 1'b0;
    push_one(5'd4, 32'h44);
    tick();
    chk("same_regwe", 32'(RegWE), 32'd1);
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    #1;
    chk("same_pause", 32'(pause), 32'b10);
    push_one(5'd4, 32'h45);
    tick(); tick();
    chk("same_pause_clear", 32'(pause), 32'b00);
    chk("same_err", 32'(err), 32'd0);

    // Unreserved commit
    read_addr1 = 5'd9; read_addr2 = 5'd0;
    push_one(5'd9, 32'h1);
    tick();
    chk("unres_regwe", 32'(RegWE), 32'd1);
    chk("unres_waddr", 32'(write_addr), 32'd9);
    chk("unres_wdata", write_data, 32'h1);
    tick();
    chk("unres_err", 32'(err), 32'd1);
    chk("unres_pause", 32'(pause), 32'b00);
    tick();
    chk("unres_err_sticky", 32'(err), 32'd1);

    // Reset mid-operation
    issue_valid = 1'b1; issue_addr = 5'd3;
    tick();
    issue_valid = 1'b0;
    ext_we = 1'b1; ext_addr = 5'd2; ext_data = 32'hCAFE;
    push_one(5'd20, 32'hB1);
    push_one(5'd21, 32'hB2);
    read_addr1 = 5'd3;
    #1;
    chk("pre_rst_pause", 32'(pause), 32'b01);
    rst = 1'b1; ext_we = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_regwe", 32'(RegWE), 32'd0);
    chk("mid_rst_waddr", 32'(write_addr), 32'd0);
    chk("mid_rst_wdata", write_data, 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_pause", 32'(pause), 32'b00);
    chk("mid_rst_res_ready", 32'(res_ready), 32'd1);
    tick();
    chk("mid_rst_empty1", 32'(RegWE), 32'd0);
    tick();
    chk("mid_rst_empty2", 32'(RegWE), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_ctrl.md
WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: result buffer entries, power of two, at least 2.
REQ-002 SHALL have parameter CNT_W, default 2: width of the per-register pending-write counter.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port issue_valid  input  1: decode reserves destination issue_addr.
REQ-006 SHALL have port issue_addr  input  5: destination register being reserved.
REQ-007 SHALL have port issue_ready  output  1: reservation accepted this cycle.
REQ-008 SHALL have port res_valid  input  1: pipeline presents a result.
REQ-009 SHALL have port res_addr  input  5: result destination register.
REQ-010 SHALL have port res_data  input  32: result value.
REQ-011 SHALL have port res_ready  output  1: result accepted this cycle.
REQ-012 SHALL have port ext_we  input  1: priority external write request, such as debug or exception.
REQ-013 SHALL have port ext_addr  input  5: external write register.
REQ-014 SHALL have port ext_data  input  32: external write value.
REQ-015 SHALL have port RegWE  output  1: register-file write enable, registered.
REQ-016 SHALL have port write_addr  output  5: register-file write address, registered.
REQ-017 SHALL have port write_data  output  32: register-file write data, registered.
REQ-018 SHALL have port read_addr1  input  5: rs being read by decode.
REQ-019 SHALL have port read_addr2  input  5: rt being read by decode.
REQ-020 SHALL have port pause  output  2: {rt pending, rs pending}, combinational.
REQ-021 SHALL have port err  output  1: sticky flag set on commit to an unreserved register.

Function
REQ-022 SHALL keep a per-register pending counter cnt[r], CNT_W bits wide, with cnt[0] always 0.
REQ-023 SHALL drive issue_ready = !(issue_addr != 0 && cnt[issue_addr] == 2^CNT_W-1), ignoring issue_valid.
REQ-024 SHALL, on an accepted issue (issue_valid && issue_ready) with issue_addr != 0, increment cnt[issue_addr]; an issue with issue_addr == 0 SHALL be accepted and SHALL have no effect.
REQ-025 SHALL buffer results in a FIFO of FIFO_DEPTH entries and drive res_ready = !full, with no push while full even if a pop occurs in the same cycle.
REQ-026 SHALL select the write source each cycle by priority: ext_we first; otherwise the FIFO head if the FIFO is non-empty; otherwise no write.
REQ-027 SHALL, when ext_we is asserted, register RegWE = (ext_addr != 0), write_addr = ext_addr and write_data = ext_data, and SHALL NOT pop the FIFO.
REQ-028 SHALL, when the FIFO head is selected, pop it and register RegWE = (head addr != 0) with the head address and data.
REQ-029 SHALL hold RegWE low, and write_addr and write_data at their previous values, on a cycle with no write source.
REQ-030 SHALL give a result accepted at edge N with an empty FIFO and no ext_we a minimum latency of RegWE high during cycle N+1.
REQ-031 SHALL, at each edge where RegWE is high and the write came from the FIFO, decrement cnt[write_addr].
REQ-032 SHALL NOT let external writes alter any counter.
REQ-033 SHALL leave the counter unchanged when an increment and a decrement of the same register occur at the same edge.
REQ-034 SHALL, on a decrement of a counter already at 0, hold the counter at 0 and set err, which stays set until reset.
REQ-035 SHALL drive pause[0] = (read_addr1 != 0 && cnt[read_addr1] != 0).
REQ-036 SHALL drive pause[1] = (read_addr2 != 0 && cnt[read_addr2] != 0).
REQ-037 SHALL keep FIFO pointers one bit wider than the address, so that full and empty are distinguished and wrap-around is correct.

Reset
REQ-038 SHALL, at any edge with rst high, clear all counters, empty the FIFO, and set RegWE = 0, write_addr = 0, write_data = 0 and err = 0, discarding any in-flight write or reservation.
REQ-039 SHALL drive pause = 2'b00, res_ready = 1 and issue_ready = 1 in the first cycle after reset.

Verification
REQ-040 SHALL cover single result: issue r5; read_addr1 = 5 gives pause = 2'b01; push (5, 0xDEADBEEF) at edge N -> RegWE = 1, write_addr = 5, write_data = 0xDEADBEEF in cycle N+1, and pause = 2'b00 from cycle N+2.
REQ-041 SHALL cover saturation: issue r7 three times -> issue_ready = 0 for addr 7 and 1 for addr 8; one commit to r7 -> issue_ready returns to 1.
REQ-042 SHALL cover FIFO full: hold ext_we high while pushing 4 results -> res_ready = 0 on the 5th; drop ext_we -> 4 consecutive RegWE cycles in push order, then res_ready = 1.
REQ-043 SHALL cover register zero: issue r0, push (0, 0x1234) -> pause stays 2'b00, RegWE stays 0, err = 0.
REQ-044 SHALL cover unreserved commit: push (9, 0x1) with cnt[9] = 0 -> write occurs, cnt[9] stays 0, err = 1 until rst.
REQ-045 SHALL cover reset mid-operation: with 2 results queued and r3 pending, assert rst for 1 cycle -> FIFO empty, RegWE = 0, pause = 2'b00 for read_addr1 = 3.
